// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// default frame marker, frame-field widths and a length range helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         LEN_WIDTH         = 16;
    localparam int         BYTES_PER_WORD    = 4;
    localparam int         WORD_WIDTH        = 32;

    // A frame length is usable when it is non-zero and fits in the memory.
    function automatic logic len_in_range(input logic [LEN_WIDTH-1:0] len,
                                          input int addr_width);
        logic [31:0] max_words;
        max_words = 32'd1 << addr_width;
        return (len != '0) && ({16'd0, len} <= max_words);
    endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte watchdog for the loader: a down-counter that reloads on clear,
// counts while enabled and flags expiry once it has run down to zero.
module loader_timeout_counter #(
    parameter int CYCLES = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int                  CNT_WIDTH  = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] LOAD_VALUE = CNT_WIDTH'(CYCLES - 1);

    logic [CNT_WIDTH-1:0] count;

    // Reload on every clear, otherwise count down while enabled and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= LOAD_VALUE;
        end else if (clear) begin
            count <= LOAD_VALUE;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed UART byte stream, writes 32-bit
// words into instruction memory and releases the core only after the frame
// checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_d,
    output logic                  core_reset_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int         LAST_W        = ADDR_WIDTH + 1;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

    state_t                 state;
    logic [7:0]             len_lo;
    logic [LAST_W-1:0]      last_word;
    logic [LAST_W-1:0]      word_cnt;
    logic [1:0]             byte_idx;
    logic [2:0][7:0]        word_buf;
    logic [7:0]             csum;
    logic [LEN_WIDTH-1:0]   len_word;
    logic                   take;
    logic                   timeout_clear;
    logic                   timeout_expire;

    assign take          = rx_valid && rx_ready;
    assign len_word      = {rx_data, len_lo};
    assign timeout_clear = take || !load_busy;

    loader_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timeout_clear),
        .enable (load_busy),
        .expire (timeout_expire)
    );

    // Frame parser: one byte per cycle, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_d       <= '0;
            core_reset_n <= 1'b0;
            load_busy    <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            len_lo       <= '0;
            last_word    <= '0;
            word_cnt     <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
            csum         <= '0;
        end else begin
            rx_ready  <= 1'b1;
            imem_we   <= 1'b0;
            load_done <= 1'b0;

            if (imem_we) begin
                imem_addr <= imem_addr + ADDR_WIDTH'(1);
            end

            if (load_busy && timeout_expire && !take) begin
                state      <= ST_ERROR;
                load_busy  <= 1'b0;
                load_error <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (take && (rx_data == SYNC_BYTE)) begin
                            state     <= ST_LEN_LO;
                            load_busy <= 1'b1;
                        end
                    end

                    ST_LEN_LO: begin
                        if (take) begin
                            len_lo <= rx_data;
                            state  <= ST_LEN_HI;
                        end
                    end

                    ST_LEN_HI: begin
                        if (take) begin
                            if (len_in_range(len_word, ADDR_WIDTH)) begin
                                last_word <= LAST_W'(len_word - 16'd1);
                                word_cnt  <= '0;
                                byte_idx  <= '0;
                                csum      <= '0;
                                imem_addr <= '0;
                                state     <= ST_DATA;
                            end else begin
                                state      <= ST_ERROR;
                                load_busy  <= 1'b0;
                                load_error <= 1'b1;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (take) begin
                            csum     <= csum + rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == LAST_BYTE_IDX) begin
                                imem_we  <= 1'b1;
                                imem_d   <= {rx_data, word_buf};
                                word_cnt <= word_cnt + LAST_W'(1);
                                if (word_cnt == last_word) begin
                                    state <= ST_CSUM;
                                end
                            end else begin
                                word_buf[byte_idx] <= rx_data;
                            end
                        end
                    end

                    ST_CSUM: begin
                        if (take) begin
                            load_busy <= 1'b0;
                            if (rx_data == csum) begin
                                state        <= ST_RUN;
                                core_reset_n <= 1'b1;
                                load_done    <= 1'b1;
                            end else begin
                                state      <= ST_ERROR;
                                load_error <= 1'b1;
                            end
                        end
                    end

                    ST_RUN: begin
                        if (take && (rx_data == SYNC_BYTE)) begin
                            state        <= ST_LEN_LO;
                            core_reset_n <= 1'b0;
                            load_busy    <= 1'b1;
                        end
                    end

                    ST_ERROR: begin
                        core_reset_n <= 1'b0;
                        if (take && (rx_data == SYNC_BYTE)) begin
                            state      <= ST_LEN_LO;
                            load_error <= 1'b0;
                            load_busy  <= 1'b1;
                        end
                    end

                    default: begin
                        state        <= ST_IDLE;
                        core_reset_n <= 1'b0;
                        load_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are modelled at byte-list level,
// expected writes and load_done pulses are queued, and a monitor retires them
// whenever the DUT strobes imem_we or load_done.
module tb_imem_loader;

    localparam int ADDR_WIDTH     = 8;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int MEM_WORDS      = 1 << ADDR_WIDTH;

    typedef logic [7:0] bytes_t [$];

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_d;
    logic                  core_reset_n;
    logic                  load_busy;
    logic                  load_done;
    logic                  load_error;

    int  checks = 0;
    int  passes = 0;
    wr_t exp_wr_q [$];
    int  exp_done_count = 0;
    wr_t mon_wr;

    imem_loader #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_d       (imem_d),
        .core_reset_n (core_reset_n),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Monitor: retire queued expectations whenever the DUT writes or finishes.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_wr_q.size() == 0) begin
                    checkOutput("unexpected_write", {31'd0, imem_we}, 32'd0);
                end else begin
                    mon_wr = exp_wr_q.pop_front();
                    checkOutput("write_addr", {24'd0, imem_addr}, {24'd0, mon_wr.addr});
                    checkOutput("write_data", imem_d, mon_wr.data);
                end
            end
            if (load_done) begin
                checkOutput("done_expected", {31'd0, exp_done_count > 0}, 32'd1);
                if (exp_done_count > 0) exp_done_count--;
            end
        end
    end

    // Reference model: decode a whole frame from its byte list.
    task automatic modelFrame(input bytes_t frame, output bit good);
        int         len;
        logic [7:0] sum;
        wr_t        w;
        good = 1'b0;
        len  = int'({frame[2], frame[1]});
        if (len == 0 || len > MEM_WORDS) return;
        sum = 8'd0;
        for (int i = 0; i < len; i++) begin
            w.addr = ADDR_WIDTH'(i % MEM_WORDS);
            w.data = {frame[3 + 4*i + 3], frame[3 + 4*i + 2],
                      frame[3 + 4*i + 1], frame[3 + 4*i]};
            for (int k = 0; k < 4; k++) sum += frame[3 + 4*i + k];
            exp_wr_q.push_back(w);
        end
        good = (frame[3 + 4*len] == sum);
    endtask

    function automatic bytes_t makeFrame(input int len, input bit corrupt);
        bytes_t     f;
        logic [7:0] sum;
        logic [7:0] b;
        sum = 8'd0;
        f.push_back(8'hA5);
        f.push_back(8'(len));
        f.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            sum += b;
            f.push_back(b);
        end
        f.push_back(corrupt ? sum + 8'd1 : sum);
        return f;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendNoise(input int count);
        logic [7:0] b;
        for (int i = 0; i < count; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            sendByte(b, 0);
        end
    endtask

    task automatic applyStimulus(input bytes_t frame, input int max_gap);
        bit good;
        int n;
        int gap;
        modelFrame(frame, good);
        if (good) exp_done_count++;
        n = frame.size();
        for (int i = 0; i < n; i++) begin
            gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
            repeat (gap) @(negedge clk);
            if (i == n - 1) checkOutput("core_held_before_last", {31'd0, core_reset_n}, 32'd0);
            sendByte(frame[i], 0);
            if (i == 0) checkOutput("core_held_after_sync", {31'd0, core_reset_n}, 32'd0);
        end
        checkOutput("core_release_timing", {31'd0, core_reset_n}, {31'd0, good});
        repeat (4) @(negedge clk);
        checkOutput("writes_drained", exp_wr_q.size(), 32'd0);
        checkOutput("done_seen", exp_done_count, 32'd0);
        checkOutput("load_error", {31'd0, load_error}, {31'd0, !good});
        checkOutput("core_reset_n", {31'd0, core_reset_n}, {31'd0, good});
        checkOutput("load_busy", {31'd0, load_busy}, 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        checkOutput({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        checkOutput({tag, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
        checkOutput({tag, "_imem_d"}, imem_d, 32'd0);
        checkOutput({tag, "_core_reset_n"}, {31'd0, core_reset_n}, 32'd0);
        checkOutput({tag, "_load_busy"}, {31'd0, load_busy}, 32'd0);
        checkOutput({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        checkOutput({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
    endtask

    // Watchdog: the run is expected to end long before this.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        bytes_t f;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        checkResetValues("reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rx_ready_in_reset", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

        $display("[TB] idle noise");
        sendNoise(3);
        checkOutput("idle_noise_core", {31'd0, core_reset_n}, 32'd0);
        checkOutput("idle_noise_busy", {31'd0, load_busy}, 32'd0);

        $display("[TB] good load");
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        applyStimulus(f, 0);
        sendNoise(2);
        checkOutput("run_noise_core", {31'd0, core_reset_n}, 32'd1);

        $display("[TB] bad checksum");
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'hB5};
        applyStimulus(f, 0);

        $display("[TB] length checks");
        f = '{8'hA5, 8'h00, 8'h00};
        applyStimulus(f, 0);
        f = '{8'hA5, 8'h01, 8'h01};
        applyStimulus(f, 0);

        $display("[TB] timeout");
        sendByte(8'hA5, 0);
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'h13, 0);
        repeat (50) @(negedge clk);
        checkOutput("timeout_busy_midway", {31'd0, load_busy}, 32'd1);
        checkOutput("timeout_err_midway", {31'd0, load_error}, 32'd0);
        repeat (55) @(negedge clk);
        checkOutput("timeout_error", {31'd0, load_error}, 32'd1);
        checkOutput("timeout_busy", {31'd0, load_busy}, 32'd0);
        checkOutput("timeout_no_write", exp_wr_q.size(), 32'd0);
        f = makeFrame(2, 1'b0);
        applyStimulus(f, 2);

        $display("[TB] reload during run");
        checkOutput("core_running_before_reload", {31'd0, core_reset_n}, 32'd1);
        f = '{8'hA5, 8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h6F};
        applyStimulus(f, 0);

        $display("[TB] reset mid-frame");
        sendByte(8'hA5, 0);
        sendByte(8'h02, 0);
        sendByte(8'h00, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        sendByte(8'h33, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetValues("midframe");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midframe_rx_ready", {31'd0, rx_ready}, 32'd1);
        f = makeFrame(3, 1'b0);
        applyStimulus(f, 1);

        $display("[TB] random frames");
        for (int r = 0; r < 8; r++) begin
            sendNoise($urandom_range(0, 2));
            f = makeFrame($urandom_range(1, 6), ($urandom_range(0, 9) < 3));
            applyStimulus(f, 3);
        end

        $display("[TB] full-memory frame");
        f = makeFrame(MEM_WORDS, 1'b0);
        applyStimulus(f, 0);
        checkOutput("addr_wrap", {24'd0, imem_addr}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
